// File: rtl/pc_gen_flush_ctrl_if.sv
// pc_gen_flush_ctrl_if: EXE/fetch-side signals of the PC generator and flush controller.
interface pc_gen_flush_ctrl_if #(
   parameter int XLEN         = 32,
   parameter int FLUSH_STAGES = 2,
   parameter int CNT_W        = 16
);
   logic                    stall_i;
   logic                    exe_valid;
   logic                    exe_is_branch;
   logic [2:0]              exe_cond;
   logic                    z_flag;
   logic                    n_flag;
   logic [XLEN-1:0]         target_pc_in;
   logic [XLEN-1:0]         pc_out;
   logic                    pc_valid;
   logic                    jump;
   logic [FLUSH_STAGES-1:0] flush_vec;
   logic                    redirect_pend;
   logic [CNT_W-1:0]        br_taken_cnt;
   modport master (
      output stall_i, exe_valid, exe_is_branch, exe_cond, z_flag, n_flag, target_pc_in,
      input  pc_out, pc_valid, jump, flush_vec, redirect_pend, br_taken_cnt
   );
   modport slave (
      input  stall_i, exe_valid, exe_is_branch, exe_cond, z_flag, n_flag, target_pc_in,
      output pc_out, pc_valid, jump, flush_vec, redirect_pend, br_taken_cnt
   );
endinterface

// File: rtl/pc_gen_flush_ctrl.sv
// pc_gen_flush_ctrl: fetch PC register, EXE branch resolution, redirect-under-stall and per-stage flush.
module pc_gen_flush_ctrl #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC     = '0,
   parameter int              INSTR_BYTES  = 4,
   parameter int              FLUSH_STAGES = 2,
   parameter int              CNT_W        = 16
) (
   input logic                clk,
   input logic                rst_n,
   pc_gen_flush_ctrl_if.slave bus
);
   logic                    cond_true;
   logic                    taken;
   logic [XLEN-1:0]         pend_pc;
   logic [FLUSH_STAGES-1:0] hist_or;
   always_comb begin
      cond_true = (bus.exe_cond == 3'd1) ? bus.z_flag :
                  (bus.exe_cond == 3'd2) ? !bus.z_flag :
                  (bus.exe_cond == 3'd3) ? bus.n_flag :
                  (bus.exe_cond == 3'd4) ? !bus.n_flag :
                  (bus.exe_cond == 3'd5);
      taken = rst_n & bus.exe_valid & bus.exe_is_branch & cond_true;
   end
   assign bus.jump      = taken;
   assign bus.pc_valid  = rst_n & !bus.stall_i & !bus.redirect_pend;
   assign bus.flush_vec = {FLUSH_STAGES{taken}} | hist_or;
   // hist_or[k] is the OR of the last k taken flags; next cycle it equals this cycle's flush_vec[k-1]
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.pc_out        <= RESET_PC;
         bus.redirect_pend <= 1'b0;
         bus.br_taken_cnt  <= '0;
         pend_pc           <= '0;
         hist_or           <= '0;
      end else begin
         hist_or          <= bus.flush_vec << 1;
         bus.br_taken_cnt <= bus.br_taken_cnt + CNT_W'(taken && !(&bus.br_taken_cnt));
         if (taken && !bus.stall_i) begin
            bus.pc_out        <= bus.target_pc_in;
            bus.redirect_pend <= 1'b0;
         end else if (taken) begin
            pend_pc           <= bus.target_pc_in;
            bus.redirect_pend <= 1'b1;
         end else if (!bus.stall_i && bus.redirect_pend) begin
            bus.pc_out        <= pend_pc;
            bus.redirect_pend <= 1'b0;
         end else if (!bus.stall_i) begin
            bus.pc_out <= bus.pc_out + XLEN'(INSTR_BYTES);
         end
      end
   end
endmodule
